vmem_arb: RTL

VMEM_ARB -- requirements
Module: vmem_arb

---
 rtl/vmem_arb_if.sv | 30 +++
 rtl/vmem_arb.sv | 95 +++++++++
 2 files changed

// File: rtl/vmem_arb_if.sv
// Display, writer and memory-side signals shared by vmem_arb and its environment.
interface vmem_arb_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
);
    logic              vga_valid;
    logic [9:0]        h_addr;
    logic [8:0]        v_addr;
    logic [DATA_W-1:0] vga_data;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [2:0]        buf_count;
    logic [15:0]       wr_done;

    modport slave (
        input  vga_valid, h_addr, v_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        output vga_data, wr_ready, mem_addr, mem_we, mem_wdata, buf_count, wr_done
    );

    modport master (
        output vga_valid, h_addr, v_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        input  vga_data, wr_ready, mem_addr, mem_we, mem_wdata, buf_count, wr_done
    );
endinterface

// File: rtl/vmem_arb.sv
// Video memory arbiter: the display reads with absolute priority, buffered writer
// requests drain into memory one per clock during blanking.
module vmem_arb #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic      clk,
    input  logic      resetn,
    vmem_arb_if.slave bus
);
    // DEPTH is a power of two >= 2 so the pointers wrap naturally.
    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef enum logic [1:0] {DISP, IDLE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [2:0]        count;
    logic              rdy_en;
    logic              rd_vld_p1;
    logic [15:0]       done_cnt;
    logic              wr_ready_i;
    logic              push, pop;

    // rdy_en keeps wr_ready low until the first clock after reset release.
    assign wr_ready_i = rdy_en && (count < DEPTH_C);
    assign push       = bus.wr_valid && wr_ready_i;
    assign pop        = (state == DRAIN) && !bus.vga_valid && (count != 3'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.vga_valid)        state_nxt = DISP;
        else if (count == 3'd0)   state_nxt = IDLE;
        else                      state_nxt = DRAIN;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= 3'd0;
            rdy_en    <= 1'b0;
            rd_vld_p1 <= 1'b0;
            done_cnt  <= 16'd0;
        end else begin
            rdy_en    <= 1'b1;
            rd_vld_p1 <= bus.vga_valid;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                done_cnt <= done_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= bus.wr_addr;
            buf_data[wr_ptr] <= bus.wr_data;
        end
    end

    // ---- p1: read data returns one clock after the display address ----
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (bus.vga_valid) begin
            bus.mem_addr = ADDR_W'({bus.h_addr, bus.v_addr});
        end else if (pop) begin
            bus.mem_addr  = buf_addr[rd_ptr];
            bus.mem_we    = 1'b1;
            bus.mem_wdata = buf_data[rd_ptr];
        end
    end

    assign bus.vga_data  = rd_vld_p1 ? bus.mem_rdata : '0;
    assign bus.wr_ready  = wr_ready_i;
    assign bus.buf_count = count;
    assign bus.wr_done   = done_cnt;
endmodule
